// File: rtl/ps2_keymap_decoder.sv
// PS/2 Set-2 scan-code decoder: held-key bitmap plus press/release/error pulses.
// Define KB_OVERRUN_CLEAR_EN to treat bytes 00/FF as keyboard overrun (clears all held keys).
module ps2_keymap_decoder #(
  parameter int unsigned            NUM_KEYS       = 8,
  parameter logic [9*NUM_KEYS-1:0]  KEY_CODES      = {9'h174, 9'h16B, 9'h172, 9'h175,
                                                      9'h023, 9'h01C, 9'h01B, 9'h01D},
  parameter int unsigned            TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [7:0]          code_in,
  input  logic                code_valid_in,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic [NUM_KEYS-1:0] press_out,
  output logic [NUM_KEYS-1:0] release_out,
  output logic                error_out
);

  localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BREAK,
    EXT_BREAK,
    PAUSE_SKIP
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                is_ovr;
  logic                do_make, do_break, ext_sel;
  logic                proto_err, tmo, ovr;
  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] keys_d, press_d, release_d;
  logic                error_d;

`ifdef KB_OVERRUN_CLEAR_EN
  assign is_ovr = (code_in == 8'h00) || (code_in == 8'hFF);
`else
  assign is_ovr = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      skip_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    cnt_d     = cnt_q;
    do_make   = 1'b0;
    do_break  = 1'b0;
    ext_sel   = 1'b0;
    proto_err = 1'b0;
    tmo       = 1'b0;
    ovr       = 1'b0;
    if (code_valid_in) begin
      cnt_d = '0;
      if (is_ovr) begin
        ovr     = 1'b1;
        state_d = IDLE;
        skip_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            case (code_in)
              8'hE0: state_d = EXT;
              8'hF0: state_d = BREAK;
              8'hE1: begin
                state_d = PAUSE_SKIP;
                skip_d  = 3'd7;
              end
              8'hAA, 8'hFA, 8'hFE, 8'hEE: state_d = IDLE;
              default: do_make = 1'b1;
            endcase
          end
          EXT: begin
            case (code_in)
              8'hF0: state_d = EXT_BREAK;
              8'hE0: state_d = EXT;
              default: begin
                do_make = 1'b1;
                ext_sel = 1'b1;
                state_d = IDLE;
              end
            endcase
          end
          BREAK, EXT_BREAK: begin
            case (code_in)
              8'hE0: begin
                proto_err = 1'b1;
                state_d   = EXT;
              end
              8'hF0: begin
                proto_err = 1'b1;
                state_d   = BREAK;
              end
              default: begin
                do_break = 1'b1;
                ext_sel  = (state_q == EXT_BREAK);
                state_d  = IDLE;
              end
            endcase
          end
          PAUSE_SKIP: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == TO_LAST) begin
      // stalled mid-sequence: abandon it, held keys stay as they are
      tmo     = 1'b1;
      state_d = IDLE;
      skip_d  = '0;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      hit[i] = (KEY_CODES[9*i +: 9] == {ext_sel, code_in});
    end
    keys_d    = keys_out;
    press_d   = '0;
    release_d = '0;
    error_d   = proto_err | tmo | ovr;
    if (do_make) begin
      keys_d  = keys_out | hit;
      press_d = hit & ~keys_out;
    end
    if (do_break) begin
      keys_d    = keys_out & ~hit;
      release_d = hit & keys_out;
    end
    if (ovr) begin
      keys_d    = '0;
      release_d = keys_out;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      keys_out    <= '0;
      press_out   <= '0;
      release_out <= '0;
      error_out   <= 1'b0;
    end else begin
      keys_out    <= keys_d;
      press_out   <= press_d;
      release_out <= release_d;
      error_out   <= error_d;
    end
  end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Bench for ps2_keymap_decoder: directed scenarios plus random byte streams against a rule-level model.
module tb_ps2_keymap_decoder;

  localparam int TO = 16;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid_in = 1'b0;
  logic [7:0] keys_out, press_out, release_out;
  logic       error_out;

  int tests = 0;
  int failed = 0;

  // index 0..7 = W, S, A, D, Up, Down, Left, Right
  logic [8:0] kc [8] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h175, 9'h172, 9'h16B, 9'h174};
  logic [7:0] ign [4] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE};

  // model: held keys, expected pulses, pending prefix, pause bytes left, idle cycles mid-sequence
  logic [7:0] m_keys = '0, e_press = '0, e_rel = '0;
  logic       e_err = 1'b0;
  bit         m_ext = 0, m_brk = 0;
  int         m_skip = 0, m_idle = 0;

  ps2_keymap_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .code_in(code_in), .code_valid_in(code_valid_in),
    .keys_out(keys_out), .press_out(press_out), .release_out(release_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [24:0] obs();
    return {keys_out, press_out, release_out, error_out};
  endfunction

  function automatic logic [24:0] expv();
    return {m_keys, e_press, e_rel, e_err};
  endfunction

  function automatic void model_clear_seq();
    m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] b);
    bit ovr_byte;
    e_press = '0; e_rel = '0; e_err = 1'b0;
`ifdef KB_OVERRUN_CLEAR_EN
    ovr_byte = (b == 8'h00) || (b == 8'hFF);
`else
    ovr_byte = 0;
`endif
    if (!v) begin
      if (m_ext || m_brk || m_skip > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          e_err = 1'b1;
          model_clear_seq();
        end
      end
    end else begin
      m_idle = 0;
      if (ovr_byte) begin
        e_rel = m_keys; m_keys = '0; e_err = 1'b1;
        model_clear_seq();
      end else if (m_skip > 0) begin
        m_skip--;
      end else if (b == 8'hE0) begin
        if (m_brk) e_err = 1'b1;
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        if (m_brk) begin e_err = 1'b1; m_ext = 0; end
        m_brk = 1;
      end else if (b == 8'hE1 && !m_ext && !m_brk) begin
        m_skip = 7;
      end else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE)) begin
        // status bytes outside a sequence are ignored
      end else begin
        for (int j = 0; j < 8; j++) begin
          if (kc[j] == {m_ext, b}) begin
            if (m_brk) begin
              if (m_keys[j]) e_rel[j] = 1'b1;
              m_keys[j] = 1'b0;
            end else begin
              if (!m_keys[j]) e_press[j] = 1'b1;
              m_keys[j] = 1'b1;
            end
          end
        end
        model_clear_seq();
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] b);
    code_valid_in = v;
    code_in = b;
    @(posedge clk_in);
    #1;
    code_valid_in = 1'b0;
    model_step(v, b);
  endtask

  task automatic test_reset();
    tests++;
    if (obs() !== 25'd0) begin
      failed++;
      $display("FAIL reset: got %h expected %h", obs(), 25'd0);
    end
  endtask

  task automatic test_make_break();
    logic [7:0] s [4] = '{8'h1D, 8'h1D, 8'hF0, 8'h1D};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s[i]);
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL make_break[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
    tests++;
    if (release_out !== 8'h01 || keys_out !== 8'h00) begin
      failed++;
      $display("FAIL make_break_final: got keys %h rel %h expected keys 00 rel 01", keys_out, release_out);
    end
  endtask

  task automatic test_extended();
    logic [7:0] s [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, s[i]);
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL extended[%0d]: got %h expected %h", i, obs(), expv());
      end
      if (i == 1) begin
        tests++;
        if (press_out !== 8'h10) begin
          failed++;
          $display("FAIL extended_press: got %h expected 10", press_out);
        end
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] s [11] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, s[i]);
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL pause[%0d]: got %h expected %h", i, obs(), expv());
      end
      if (i == 8) begin
        tests++;
        if (keys_out !== 8'h04) begin
          failed++;
          $display("FAIL pause_after: got keys %h expected 04", keys_out);
        end
      end
    end
  endtask

  task automatic test_timeout();
    drive(1'b1, 8'hE0);
    for (int i = 1; i <= TO; i++) begin
      drive(1'b0, 8'h00);
      tests++;
      if (obs() !== expv() || error_out !== (i == TO)) begin
        failed++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
    drive(1'b1, 8'h72);
    tests++;
    if (obs() !== expv() || keys_out !== 8'h00) begin
      failed++;
      $display("FAIL timeout_after: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_timeout_race();
    logic [7:0] s [4] = '{8'h75, 8'hE0, 8'hF0, 8'h75};
    drive(1'b1, 8'hE0);
    for (int i = 1; i < TO; i++) drive(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s[i]);
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL timeout_race[%0d]: got %h expected %h", i, obs(), expv());
      end
      if (i == 0) begin
        tests++;
        if (error_out !== 1'b0 || keys_out !== 8'h10) begin
          failed++;
          $display("FAIL timeout_race_win: got err %b keys %h expected err 0 keys 10", error_out, keys_out);
        end
      end
    end
  endtask

  task automatic test_protocol_error();
    logic [7:0] s [7] = '{8'hF0, 8'hF0, 8'h23, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[i]);
      tests++;
      if (obs() !== expv() || error_out !== (i == 1)) begin
        failed++;
        $display("FAIL protocol_error[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h1D);
    drive(1'b1, 8'hE0);
    drive(1'b1, 8'hF0);
    #3 rst_n_in = 1'b0;
    #1;
    tests++;
    if (obs() !== 25'd0) begin
      failed++;
      $display("FAIL reset_mid: got %h expected %h", obs(), 25'd0);
    end
    m_keys = '0;
    model_clear_seq();
    rst_n_in = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h75);
    tests++;
    if (obs() !== expv()) begin
      failed++;
      $display("FAIL reset_mid_after: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_overrun();
    drive(1'b1, 8'h1D);
    drive(1'b1, 8'h23);
    drive(1'b1, 8'h00);
    tests++;
    if (obs() !== expv()) begin
      failed++;
      $display("FAIL overrun_model: got %h expected %h", obs(), expv());
    end
    tests++;
`ifdef KB_OVERRUN_CLEAR_EN
    if (keys_out !== 8'h00 || release_out !== 8'h09 || error_out !== 1'b1) begin
      failed++;
      $display("FAIL overrun: got keys %h rel %h err %b expected 00 09 1", keys_out, release_out, error_out);
    end
`else
    if (keys_out !== 8'h09 || release_out !== 8'h00 || error_out !== 1'b0) begin
      failed++;
      $display("FAIL overrun: got keys %h rel %h err %b expected 09 00 0", keys_out, release_out, error_out);
    end
`endif
    drive(1'b1, 8'hF0); drive(1'b1, 8'h1D);
    drive(1'b1, 8'hF0); drive(1'b1, 8'h23);
    tests++;
    if (obs() !== expv()) begin
      failed++;
      $display("FAIL overrun_cleanup: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    int idle_run = 0;
    logic       v;
    logic [7:0] b;
    int         k;
    for (int n = 0; n < 1500; n++) begin
      v = 1'b0;
      b = 8'h00;
      if (idle_run > 0) begin
        idle_run--;
      end else if ($urandom_range(0, 99) < 3) begin
        idle_run = TO + 1;
      end else if ($urandom_range(0, 99) < 30) begin
        v = 1'b0;
      end else begin
        v = 1'b1;
        k = $urandom_range(0, 12);
        case (k)
          0, 1, 2, 3: b = kc[$urandom_range(0, 7)][7:0];
          4, 5:       b = 8'hE0;
          6, 7:       b = 8'hF0;
          8:          b = 8'hE1;
          9:          b = ign[$urandom_range(0, 3)];
          10:         b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
          default:    b = 8'($urandom_range(0, 255));
        endcase
      end
      drive(v, b);
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL random[%0d] v=%b b=%h: got %h expected %h", n, v, b, obs(), expv());
      end
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    test_reset();
    rst_n_in = 1'b1;
    test_make_break();
    test_extended();
    test_pause();
    test_timeout();
    test_timeout_race();
    test_protocol_error();
    test_reset_mid();
    test_overrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
